// File: rtl/c_register_file.sv
// Multi-entry register file: one write port, two registered read ports with
// optional write-through bypass, and a per-entry busy scoreboard.
module c_register_file #(
    parameter int BITS      = 16,
    parameter int DEPTH     = 8,
    parameter int ADDR_BITS = 3,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 save,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [BITS-1:0]      in,
    input  logic                 reserve,
    input  logic [ADDR_BITS-1:0] rsv_addr,
    input  logic [ADDR_BITS-1:0] raddr_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [BITS-1:0]      out_a,
    output logic [BITS-1:0]      out_b,
    output logic                 busy_a,
    output logic                 busy_b
);

    logic [BITS-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [BITS-1:0]  rd_a;
    logic [BITS-1:0]  rd_b;
    logic             we;
    logic             rv;
    logic             byp_a;
    logic             byp_b;

    function automatic logic writable(input logic [ADDR_BITS-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign we    = save && writable(waddr);
    assign rv    = reserve && writable(rsv_addr);
    assign byp_a = (BYPASS != 0) && we && (waddr == raddr_a);
    assign byp_b = (BYPASS != 0) && we && (waddr == raddr_b);

    // Out-of-range addresses match no entry and read as 0; the zero register
    // is never written or reserved, so it needs no special case here.
    always_comb begin
        rd_a   = '0;
        rd_b   = '0;
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == ADDR_BITS'(i)) begin
                rd_a   = mem[i];
                busy_a = busy[i];
            end
            if (raddr_b == ADDR_BITS'(i)) begin
                rd_b   = mem[i];
                busy_b = busy[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy  <= '0;
            out_a <= '0;
            out_b <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy  <= '0;
            out_a <= '0;
            out_b <= '0;
        end else begin
            // A reservation on the entry being written wins: the new producer
            // keeps it busy even though the old producer's data lands.
            for (int i = 0; i < DEPTH; i++) begin
                if (we && (waddr == ADDR_BITS'(i))) mem[i] <= in;
                if (rv && (rsv_addr == ADDR_BITS'(i)))
                    busy[i] <= 1'b1;
                else if (we && (waddr == ADDR_BITS'(i)))
                    busy[i] <= 1'b0;
            end
            out_a <= byp_a ? in : rd_a;
            out_b <= byp_b ? in : rd_b;
        end
    end

endmodule
